status_flag_capture: RTL and testbench

//   Builds the 13-bit peripheral status vector that feeds the interrupt stage.

---
 rtl/status_flag_capture.sv | 83 ++++++++
 tb/tb_status_flag_capture.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/status_flag_capture.sv
// status_flag_capture
//   Builds the registered peripheral status vector that feeds the interrupt stage.
//   Each bit is either sticky or live:
//   - Sticky bits set on an event and are held until software clears them
//     (write-1-to-clear). An event sets the bit either on a rising edge of its
//     input or whenever the input is high (level mode).
//   - Live bits are a registered copy of their input, one cycle late.
//   Events that arrive while their sticky bit is already set are lost. Lost
//   events are counted in a saturating debug counter.
//
// Ports
//   clk            system clock; all state updates on the rising edge
//   n_rst          asynchronous active-low reset
//   event_in       raw event/level inputs, synchronous to clk
//   clear_en       software write strobe to the status register
//   clear_mask     write data; 1 clears the matching sticky bit
//   overrun_clear  zeroes overrun_count
//   status         registered status vector
//   overrun_count  saturating count of lost sticky events
module status_flag_capture #(
   parameter int unsigned           WIDTH       = 13,
   parameter logic [WIDTH-1:0]      STICKY_MASK = 13'h006D,
   parameter logic [WIDTH-1:0]      EDGE_MASK   = 13'h0024,
   parameter int unsigned           CNT_W       = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [WIDTH-1:0] event_in,
   input  logic             clear_en,
   input  logic [WIDTH-1:0] clear_mask,
   input  logic             overrun_clear,
   output logic [WIDTH-1:0] status,
   output logic [CNT_W-1:0] overrun_count
);

   logic [WIDTH-1:0] event_prev_q, event_prev_d;
   logic [WIDTH-1:0] status_q, status_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [WIDTH-1:0] set_vec;
   logic [WIDTH-1:0] clr_vec;
   logic [WIDTH-1:0] sticky_next;
   logic [WIDTH-1:0] lost_vec;

   always_comb begin
      event_prev_d = event_in;

      clr_vec = {WIDTH{clear_en}} & clear_mask;

      // Edge-mode bits fire only on a 0->1 transition; level-mode bits fire while high.
      set_vec = (EDGE_MASK & event_in & ~event_prev_q) | (~EDGE_MASK & event_in);

      // Set wins over a simultaneous clear.
      sticky_next = set_vec | (status_q & ~clr_vec);
      status_d    = (STICKY_MASK & sticky_next) | (~STICKY_MASK & event_in);

      // An event is lost only if its bit is set and stays set through this cycle's clear.
      lost_vec = STICKY_MASK & set_vec & status_q & ~clr_vec;

      count_d = count_q;
      if (overrun_clear) begin
         count_d = '0;
      end else if ((|lost_vec) && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         event_prev_q <= '0;
         status_q     <= '0;
         count_q      <= '0;
      end else begin
         event_prev_q <= event_prev_d;
         status_q     <= status_d;
         count_q      <= count_d;
      end
   end

   assign status        = status_q;
   assign overrun_count = count_q;

endmodule

// File: tb/tb_status_flag_capture.sv
// tb_status_flag_capture
//   Directed-vector bench for status_flag_capture with hand-computed expectations.
module tb_status_flag_capture;

   logic        clk;
   logic        n_rst;
   logic [12:0] event_in;
   logic        clear_en;
   logic [12:0] clear_mask;
   logic        overrun_clear;
   logic [12:0] status;
   logic [7:0]  overrun_count;

   int n_tests;
   int n_fail;

   status_flag_capture dut (
      .clk           (clk),
      .n_rst         (n_rst),
      .event_in      (event_in),
      .clear_en      (clear_en),
      .clear_mask    (clear_mask),
      .overrun_clear (overrun_clear),
      .status        (status),
      .overrun_count (overrun_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      n_rst         = 1'b0;
      event_in      = 13'h1FFF;
      clear_en      = 1'b0;
      clear_mask    = '0;
      overrun_clear = 1'b0;

      // 1 reset
      step();
      step();
      check("rst_status", 32'(status), 32'h0);
      check("rst_count", 32'(overrun_count), 32'h0);
      n_rst = 1'b1;
      step();
      check("post_rst_status", 32'(status), 32'h1FFF);
      check("post_rst_count", 32'(overrun_count), 32'h0);
      event_in = '0;
      step();
      check("sticky_hold", 32'(status), 32'h006D);
      clear_en   = 1'b1;
      clear_mask = 13'h1FFF;
      step();
      check("clear_all", 32'(status), 32'h0);
      clear_en   = 1'b0;
      clear_mask = '0;

      // 2 edge sticky
      event_in = 13'h0004;
      step();
      check("edge_set", 32'(status), 32'h0004);
      event_in = '0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("edge_held", 32'(status[2]), 32'h1);
      end
      clear_en   = 1'b1;
      clear_mask = 13'h0004;
      step();
      check("edge_clear", 32'(status), 32'h0);
      clear_en   = 1'b0;
      clear_mask = '0;

      // 3 set vs clear
      event_in = 13'h0020;
      step();
      event_in = '0;
      step();
      check("b5_set", 32'(status), 32'h0020);
      event_in   = 13'h0020;
      clear_en   = 1'b1;
      clear_mask = 13'h0020;
      step();
      check("set_wins", 32'(status[5]), 32'h1);
      check("set_wins_count", 32'(overrun_count), 32'h0);
      event_in = '0;
      step();
      check("b5_cleared", 32'(status), 32'h0);
      clear_en   = 1'b0;
      clear_mask = '0;

      // 4 overrun
      event_in = 13'h0001;
      step();
      event_in = '0;
      step();
      check("b0_set_count", 32'(overrun_count), 32'h0);
      for (int i = 0; i < 3; i++) begin
         event_in = 13'h0001;
         step();
         event_in = '0;
         step();
      end
      check("overrun_3", 32'(overrun_count), 32'h3);
      event_in = 13'h0048;
      step();
      event_in = '0;
      step();
      check("b36_first", 32'(overrun_count), 32'h3);
      event_in = 13'h0048;
      step();
      event_in = '0;
      step();
      check("overrun_multi", 32'(overrun_count), 32'h4);
      check("status_0_3_6", 32'(status), 32'h0049);

      // 5 saturation: bit 0 level-held high loses one event per cycle
      event_in = 13'h0001;
      for (int i = 0; i < 300; i++) step();
      check("saturate", 32'(overrun_count), 32'hFF);
      clear_en   = 1'b1;
      clear_mask = 13'h0001;
      step();
      check("level_clear_no_effect", 32'(status[0]), 32'h1);
      clear_en      = 1'b0;
      clear_mask    = '0;
      overrun_clear = 1'b1;
      step();
      check("clear_priority", 32'(overrun_count), 32'h0);
      overrun_clear = 1'b0;
      event_in      = '0;
      step();
      check("count_stays_0", 32'(overrun_count), 32'h0);

      // 6 live bits, clear_mask on a live bit does nothing
      clear_en   = 1'b1;
      clear_mask = 13'h0002;
      event_in   = 13'h0000;
      step();
      check("live_0a", 32'(status[1]), 32'h0);
      event_in = 13'h0002;
      step();
      check("live_1a", 32'(status[1]), 32'h1);
      step();
      check("live_1b", 32'(status[1]), 32'h1);
      event_in = 13'h0000;
      step();
      check("live_0b", 32'(status[1]), 32'h0);
      clear_en   = 1'b0;
      clear_mask = '0;

      // Asynchronous reset mid-operation
      event_in = 13'h0001;
      step();
      event_in = '0;
      step();
      check("pre_reset_count", 32'(overrun_count), 32'h1);
      #2;
      n_rst = 1'b0;
      #1;
      check("async_rst_status", 32'(status), 32'h0);
      check("async_rst_count", 32'(overrun_count), 32'h0);
      step();
      n_rst = 1'b1;
      step();
      check("after_rst_idle", 32'(status), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
